div_umc_prog: RTL



---
 rtl/div_umc_pkg.sv | 49 ++++
 rtl/div_umc_sync2.sv | 35 +++
 rtl/div_umc_prog.sv | 124 ++++++++++++
 3 files changed

// File: rtl/div_umc_pkg.sv
// Shared definitions for the programmable UMC master-clock divider.
// Holds the mode encoding, the per-mode ratio lookup and the parameter legality check.
package div_umc_pkg;

    typedef enum logic [1:0] {
        MODE_NTSC  = 2'd0,
        MODE_PAL   = 2'd1,
        MODE_DENDY = 2'd2,
        MODE_TEST  = 2'd3
    } mode_e;

    typedef struct packed {
        int unsigned n;
        int unsigned hi;
    } ratio_t;

    function automatic ratio_t mode_ratio(
        input logic [1:0]  mode,
        input int unsigned n0,
        input int unsigned n1,
        input int unsigned n2,
        input int unsigned n3,
        input int unsigned h0,
        input int unsigned h1,
        input int unsigned h2,
        input int unsigned h3
    );
        ratio_t r;
        case (mode)
            MODE_NTSC:  begin r.n = n0; r.hi = h0; end
            MODE_PAL:   begin r.n = n1; r.hi = h1; end
            MODE_DENDY: begin r.n = n2; r.hi = h2; end
            MODE_TEST:  begin r.n = n3; r.hi = h3; end
            default:    begin r.n = n0; r.hi = h0; end
        endcase
        return r;
    endfunction

    // A period must fit the counter and phi needs at least one high and one low cycle.
    function automatic bit ratio_legal(
        input int unsigned n,
        input int unsigned hi,
        input int unsigned cnt_w
    );
        return (n >= 32'd2) && (n <= (32'd1 << cnt_w)) &&
               (hi >= 32'd1) && (hi <= n - 32'd1);
    endfunction

endpackage

// File: rtl/div_umc_sync2.sv
// Two-flop synchroniser for a multi-bit quasi-static pin, async active-high reset to 0.
module div_umc_sync2 #(
    parameter int W = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    logic [W-1:0] meta_q;
    logic [W-1:0] meta_d;
    logic [W-1:0] sync_q;
    logic [W-1:0] sync_d;

    // Next-state for the two stages of the chain.
    always_comb begin
        meta_d = d;
        sync_d = meta_q;
    end

    // Synchroniser stages.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta_q <= {W{1'b0}};
            sync_q <= {W{1'b0}};
        end else begin
            meta_q <= meta_d;
            sync_q <= sync_d;
        end
    end

    assign q = sync_q;

endmodule

// File: rtl/div_umc_prog.sv
// Programmable master-clock divider: four selectable period/duty ratios, mode changes
// applied only at period boundaries, with hold, forced resync and registered edge strobes.
module div_umc_prog
    import div_umc_pkg::*;
#(
    parameter int unsigned CNT_W  = 5,
    parameter int unsigned DIV_N0 = 12,
    parameter int unsigned DIV_N1 = 16,
    parameter int unsigned DIV_N2 = 15,
    parameter int unsigned DIV_N3 = 8,
    parameter int unsigned HI_N0  = 7,
    parameter int unsigned HI_N1  = 10,
    parameter int unsigned HI_N2  = 9,
    parameter int unsigned HI_N3  = 5
) (
    input  logic             port_CLK,
    input  logic             port_RES,
    input  logic [1:0]       port_mode,
    input  logic             port_hold,
    input  logic             port_sync,
    output logic             port_phi,
    output logic             port_phi_rise,
    output logic             port_phi_fall,
    output logic [CNT_W-1:0] port_cnt,
    output logic [1:0]       port_mode_act
);

    localparam bit CFG_OK = ratio_legal(DIV_N0, HI_N0, CNT_W) &&
                            ratio_legal(DIV_N1, HI_N1, CNT_W) &&
                            ratio_legal(DIV_N2, HI_N2, CNT_W) &&
                            ratio_legal(DIV_N3, HI_N3, CNT_W);

    if (!CFG_OK) begin : g_cfg_err
        $error("div_umc_prog: illegal DIV_N/HI_N parameter set for CNT_W");
    end

    localparam logic [CNT_W-1:0] CNT_RST = CNT_W'(DIV_N0 - 32'd1);

    logic [1:0]       mode_s;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             phi_q;
    logic             phi_d;
    logic             rise_q;
    logic             rise_d;
    logic             fall_q;
    logic             fall_d;
    logic [1:0]       mode_act_q;
    logic [1:0]       mode_act_d;
    ratio_t           cur_s;
    ratio_t           nxt_s;
    logic [CNT_W-1:0] last_s;

    div_umc_sync2 #(
        .W (2)
    ) u_mode_sync (
        .clk (port_CLK),
        .rst (port_RES),
        .d   (port_mode),
        .q   (mode_s)
    );

    // Period counter, phase level and strobes; sync outranks hold, hold outranks counting.
    always_comb begin
        cur_s      = mode_ratio(mode_act_q, DIV_N0, DIV_N1, DIV_N2, DIV_N3,
                                HI_N0, HI_N1, HI_N2, HI_N3);
        last_s     = CNT_W'(cur_s.n - 32'd1);
        nxt_s      = cur_s;
        cnt_d      = cnt_q;
        phi_d      = phi_q;
        mode_act_d = mode_act_q;
        rise_d     = 1'b0;
        fall_d     = 1'b0;
        if (port_sync) begin
            cnt_d      = {CNT_W{1'b0}};
            mode_act_d = mode_s;
            phi_d      = 1'b1;
            rise_d     = ~phi_q;
            fall_d     = 1'b0;
        end else if (port_hold) begin
            cnt_d      = cnt_q;
            phi_d      = phi_q;
            mode_act_d = mode_act_q;
        end else begin
            // The new mode is only adopted on the wrap so a period is never cut short.
            if (cnt_q == last_s) begin
                cnt_d      = {CNT_W{1'b0}};
                mode_act_d = mode_s;
            end else begin
                cnt_d      = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
                mode_act_d = mode_act_q;
            end
            nxt_s  = mode_ratio(mode_act_d, DIV_N0, DIV_N1, DIV_N2, DIV_N3,
                                HI_N0, HI_N1, HI_N2, HI_N3);
            phi_d  = (32'(cnt_d) < nxt_s.hi);
            rise_d = phi_d & ~phi_q;
            fall_d = ~phi_d & phi_q;
        end
    end

    // State and output registers.
    always_ff @(posedge port_CLK or posedge port_RES) begin
        if (port_RES) begin
            cnt_q      <= CNT_RST;
            phi_q      <= 1'b0;
            rise_q     <= 1'b0;
            fall_q     <= 1'b0;
            mode_act_q <= 2'd0;
        end else begin
            cnt_q      <= cnt_d;
            phi_q      <= phi_d;
            rise_q     <= rise_d;
            fall_q     <= fall_d;
            mode_act_q <= mode_act_d;
        end
    end

    assign port_phi      = phi_q;
    assign port_phi_rise = rise_q;
    assign port_phi_fall = fall_q;
    assign port_cnt      = cnt_q;
    assign port_mode_act = mode_act_q;

endmodule
